// File: rtl/axi_pkg.sv
// Shared AXI-Lite channel structs and response encodings used by initiators and responders.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY    = 2'h0;
    localparam logic [1:0] RESP_SLVERR  = 2'h2;
    localparam logic [1:0] RESP_DECERR  = 2'h3;
    // A watchdog abort reuses the DECERR code; rsp_timeout tells the two apart.
    localparam logic [1:0] RESP_TIMEOUT = RESP_DECERR;

    typedef struct packed {
        logic [31:0] awaddr;
        logic        awvalid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wvalid;
        logic        bready;
        logic [31:0] araddr;
        logic        arvalid;
        logic        rready;
    } axi_lite_mosi;

    typedef struct packed {
        logic        awready;
        logic        wready;
        logic [1:0]  bresp;
        logic        bvalid;
        logic        arready;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        rvalid;
    } axi_lite_miso;

endpackage

// File: rtl/axi_lite_wdog.sv
// Transaction watchdog: up-counter loaded to zero by clr, advancing while en, saturating at TIMEOUT-1.
// expire flags the last allowed cycle; TIMEOUT = 0 never expires.
module axi_lite_wdog #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int            CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    logic [CW-1:0] count_r;

    // Cycle counter for the transaction in flight
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (en && (count_r != LAST)) begin
            count_r <= count_r + 1'b1;
        end else begin
            count_r <= count_r;
        end
    end

    assign expire = (TIMEOUT != 0) && en && (count_r == LAST);

endmodule

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI-Lite initiator: turns a command/response handshake into AXI-Lite
// read/write transactions with a per-transaction watchdog. All outputs are registered.
module axi_lite_master
    import axi_pkg::*;
#(
    parameter int TIMEOUT = 256
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_we,
    input  logic [31:0]  cmd_addr,
    input  logic [31:0]  cmd_wdata,
    output logic         rsp_valid,
    output logic [31:0]  rsp_rdata,
    output logic [1:0]   rsp_resp,
    output logic         rsp_timeout,
    output axi_lite_mosi axio_o,
    input  axi_lite_miso axii_i
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_WRESP = 3'd2,
        ST_RADDR = 3'd3,
        ST_RDATA = 3'd4
    } state_t;

    state_t       state_r, state_s;
    axi_lite_mosi mosi_r, mosi_s;
    logic         cmd_ready_r, cmd_ready_s;
    logic         rsp_valid_r, rsp_valid_s;
    logic [31:0]  rsp_rdata_r, rsp_rdata_s;
    logic [1:0]   rsp_resp_r, rsp_resp_s;
    logic         rsp_timeout_r, rsp_timeout_s;
    logic         aw_done_r, aw_done_s;
    logic         w_done_r, w_done_s;
    logic         abort_s, expire_s, accept_s;
    logic         aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;

    function automatic axi_lite_mosi clear_hs(input axi_lite_mosi m);
        axi_lite_mosi r;
        r         = m;
        r.awvalid = 1'b0;
        r.wvalid  = 1'b0;
        r.bready  = 1'b0;
        r.arvalid = 1'b0;
        r.rready  = 1'b0;
        return r;
    endfunction

    assign accept_s = cmd_valid && cmd_ready_r && (state_r == ST_IDLE);
    // A responder ready only counts while our own valid/ready is up.
    assign aw_hs_s  = mosi_r.awvalid && axii_i.awready;
    assign w_hs_s   = mosi_r.wvalid  && axii_i.wready;
    assign b_hs_s   = mosi_r.bready  && axii_i.bvalid;
    assign ar_hs_s  = mosi_r.arvalid && axii_i.arready;
    assign r_hs_s   = mosi_r.rready  && axii_i.rvalid;

    axi_lite_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk    (clk),
        .rstn   (rstn),
        .clr    (accept_s),
        .en     (state_r != ST_IDLE),
        .expire (expire_s)
    );

    // Next-state and next-output logic; a final response handshake beats a same-cycle expiry
    always_comb begin
        state_s       = state_r;
        mosi_s        = mosi_r;
        aw_done_s     = aw_done_r;
        w_done_s      = w_done_r;
        rsp_valid_s   = 1'b0;
        rsp_rdata_s   = rsp_rdata_r;
        rsp_resp_s    = rsp_resp_r;
        rsp_timeout_s = rsp_timeout_r;
        abort_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    aw_done_s = 1'b0;
                    w_done_s  = 1'b0;
                    if (cmd_we) begin
                        mosi_s.awaddr  = cmd_addr;
                        mosi_s.wdata   = cmd_wdata;
                        mosi_s.wstrb   = 4'hF;
                        mosi_s.awvalid = 1'b1;
                        mosi_s.wvalid  = 1'b1;
                        state_s        = ST_WRITE;
                    end else begin
                        mosi_s.araddr  = cmd_addr;
                        mosi_s.arvalid = 1'b1;
                        state_s        = ST_RADDR;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (expire_s) begin
                    abort_s = 1'b1;
                end else begin
                    if (aw_hs_s) begin
                        mosi_s.awvalid = 1'b0;
                        aw_done_s      = 1'b1;
                    end else begin
                        aw_done_s = aw_done_r;
                    end
                    if (w_hs_s) begin
                        mosi_s.wvalid = 1'b0;
                        w_done_s      = 1'b1;
                    end else begin
                        w_done_s = w_done_r;
                    end
                    if ((aw_done_r || aw_hs_s) && (w_done_r || w_hs_s)) begin
                        mosi_s.bready = 1'b1;
                        state_s       = ST_WRESP;
                    end else begin
                        state_s = ST_WRITE;
                    end
                end
            end
            ST_WRESP: begin
                if (b_hs_s) begin
                    mosi_s.bready = 1'b0;
                    rsp_valid_s   = 1'b1;
                    rsp_rdata_s   = 32'h0000_0000;
                    rsp_resp_s    = axii_i.bresp;
                    rsp_timeout_s = 1'b0;
                    state_s       = ST_IDLE;
                end else if (expire_s) begin
                    abort_s = 1'b1;
                end else begin
                    state_s = ST_WRESP;
                end
            end
            ST_RADDR: begin
                if (expire_s) begin
                    abort_s = 1'b1;
                end else if (ar_hs_s) begin
                    mosi_s.arvalid = 1'b0;
                    mosi_s.rready  = 1'b1;
                    state_s        = ST_RDATA;
                end else begin
                    state_s = ST_RADDR;
                end
            end
            ST_RDATA: begin
                if (r_hs_s) begin
                    mosi_s.rready = 1'b0;
                    rsp_valid_s   = 1'b1;
                    rsp_rdata_s   = axii_i.rdata;
                    rsp_resp_s    = axii_i.rresp;
                    rsp_timeout_s = 1'b0;
                    state_s       = ST_IDLE;
                end else if (expire_s) begin
                    abort_s = 1'b1;
                end else begin
                    state_s = ST_RDATA;
                end
            end
            default: begin
                mosi_s  = clear_hs(mosi_r);
                state_s = ST_IDLE;
            end
        endcase
        if (abort_s) begin
            mosi_s        = clear_hs(mosi_r);
            rsp_valid_s   = 1'b1;
            rsp_rdata_s   = 32'h0000_0000;
            rsp_resp_s    = RESP_TIMEOUT;
            rsp_timeout_s = 1'b1;
            state_s       = ST_IDLE;
        end else begin
            state_s = state_s;
        end
        cmd_ready_s = (state_s == ST_IDLE);
    end

    // State and registered-output update
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r       <= ST_IDLE;
            mosi_r        <= '0;
            cmd_ready_r   <= 1'b1;
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= 32'h0000_0000;
            rsp_resp_r    <= 2'h0;
            rsp_timeout_r <= 1'b0;
            aw_done_r     <= 1'b0;
            w_done_r      <= 1'b0;
        end else begin
            state_r       <= state_s;
            mosi_r        <= mosi_s;
            cmd_ready_r   <= cmd_ready_s;
            rsp_valid_r   <= rsp_valid_s;
            rsp_rdata_r   <= rsp_rdata_s;
            rsp_resp_r    <= rsp_resp_s;
            rsp_timeout_r <= rsp_timeout_s;
            aw_done_r     <= aw_done_s;
            w_done_r      <= w_done_s;
        end
    end

    assign axio_o      = mosi_r;
    assign cmd_ready   = cmd_ready_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_rdata   = rsp_rdata_r;
    assign rsp_resp    = rsp_resp_r;
    assign rsp_timeout = rsp_timeout_r;

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: a configurable register-slave model as responder and a
// scoreboard queue of expected responses compared as each rsp_valid pulse arrives.
module tb_axi_lite_master;
    import axi_pkg::*;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        to;
    } exp_t;

    logic         clk = 1'b0;
    logic         rstn;
    logic         cmd_valid, cmd_ready, cmd_we;
    logic [31:0]  cmd_addr, cmd_wdata;
    logic         rsp_valid, rsp_timeout;
    logic [31:0]  rsp_rdata;
    logic [1:0]   rsp_resp;
    axi_lite_mosi axio;
    axi_lite_miso axii;

    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb[$];
    exp_t e;

    // responder configuration
    int   cfg_aw_dly = 0, cfg_w_dly = 0;
    logic cfg_ar_never = 1'b0, cfg_b_never = 1'b0;

    always #5 clk = ~clk;

    axi_lite_master #(.TIMEOUT(16)) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .rsp_timeout(rsp_timeout), .axio_o(axio), .axii_i(axii)
    );

    // ---------------- responder model ----------------
    int          aw_cnt, w_cnt;
    logic        got_aw, got_w, s_bvalid, s_rvalid;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] wa, wd, s_rdata;
    logic [31:0] mem [0:7];
    logic        aw_hs, w_hs, ar_hs;
    logic [31:0] wr_addr, wr_data;

    always_comb begin
        axii.awready = axio.awvalid && !got_aw && (aw_cnt >= cfg_aw_dly);
        axii.wready  = axio.wvalid && !got_w && (w_cnt >= cfg_w_dly);
        axii.bvalid  = s_bvalid;
        axii.bresp   = s_bresp;
        axii.arready = axio.arvalid && !cfg_ar_never && !s_rvalid;
        axii.rvalid  = s_rvalid;
        axii.rdata   = s_rdata;
        axii.rresp   = s_rresp;
    end
    assign aw_hs   = axio.awvalid && axii.awready;
    assign w_hs    = axio.wvalid && axii.wready;
    assign ar_hs   = axio.arvalid && axii.arready;
    assign wr_addr = got_aw ? wa : axio.awaddr;
    assign wr_data = got_w ? wd : axio.wdata;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            aw_cnt <= 0; w_cnt <= 0; got_aw <= 1'b0; got_w <= 1'b0;
            s_bvalid <= 1'b0; s_bresp <= 2'h0; s_rvalid <= 1'b0;
            s_rdata <= 32'h0; s_rresp <= 2'h0; wa <= 32'h0; wd <= 32'h0;
            for (int i = 0; i < 8; i++) mem[i] <= 32'h0;
        end else begin
            aw_cnt <= (axio.awvalid && !aw_hs) ? aw_cnt + 1 : 0;
            w_cnt  <= (axio.wvalid && !w_hs) ? w_cnt + 1 : 0;
            if (aw_hs) begin got_aw <= 1'b1; wa <= axio.awaddr; end
            if (w_hs) begin got_w <= 1'b1; wd <= axio.wdata; end
            if (!s_bvalid && !cfg_b_never && (got_aw || aw_hs) && (got_w || w_hs)) begin
                s_bvalid <= 1'b1;
                got_aw   <= 1'b0;
                got_w    <= 1'b0;
                if (wr_addr == 32'h0000_0008) s_bresp <= RESP_DECERR;
                else begin s_bresp <= RESP_OKAY; mem[wr_addr[4:2]] <= wr_data; end
            end else if (s_bvalid && axio.bready) s_bvalid <= 1'b0;
            if (ar_hs) begin
                s_rvalid <= 1'b1;
                if (axio.araddr == 32'h0) begin s_rdata <= 32'h2904_2023; s_rresp <= RESP_OKAY; end
                else if (axio.araddr == 32'h8) begin s_rdata <= 32'h0; s_rresp <= RESP_DECERR; end
                else begin s_rdata <= mem[axio.araddr[4:2]]; s_rresp <= RESP_OKAY; end
            end else if (s_rvalid && axio.rready) s_rvalid <= 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic we, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = d;
        for (int i = 0; i < 100 && cmd_ready !== 1'b1; i++) @(negedge clk);
        n_chk++;
        if (cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL accept: cmd_ready=%b required 1", cmd_ready);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int max, output int cyc);
        cyc = -1;
        for (int c = 1; c <= max; c++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin cyc = c; break; end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rstn = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout} !== {1'b1, 1'b0, 32'h0, 2'h0, 1'b0}) begin
            n_fail++; $display("FAIL reset_rsp: got %b/%b/%h/%h/%b required 1/0/0/0/0",
                               cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout);
        end
        n_chk++;
        if (axio !== '0) begin n_fail++; $display("FAIL reset_axi: axio=%h required 0", axio); end
        rstn = 1'b1;
        @(negedge clk);
        n_chk++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: %b required 1", cmd_ready); end
    endtask

    task automatic test_id_read();
        int cyc;
        send(1'b0, 32'h0, 32'h0);
        sb.push_back({32'h2904_2023, RESP_OKAY, 1'b0});
        wait_rsp(40, cyc);
        e = sb.pop_front();
        n_chk++;
        if ({rsp_rdata, rsp_resp, rsp_timeout} !== e || cyc != 3) begin
            n_fail++; $display("FAIL id_read: got %h/%h/%b at %0d required %h/%h/%b at 3",
                               rsp_rdata, rsp_resp, rsp_timeout, cyc, e.rdata, e.resp, e.to);
        end
        send(1'b0, 32'h8, 32'h0);
        sb.push_back({32'h0, RESP_DECERR, 1'b0});
        wait_rsp(40, cyc);
        e = sb.pop_front();
        n_chk++;
        if ({rsp_rdata, rsp_resp, rsp_timeout} !== e) begin
            n_fail++; $display("FAIL decerr_read: got %h/%h/%b required %h/%h/%b",
                               rsp_rdata, rsp_resp, rsp_timeout, e.rdata, e.resp, e.to);
        end
    endtask

    task automatic test_write_read();
        int cyc;
        send(1'b1, 32'h0000_000C, 32'h0000_C350);
        sb.push_back({32'h0, RESP_OKAY, 1'b0});
        wait_rsp(40, cyc);
        e = sb.pop_front();
        n_chk++;
        if ({rsp_rdata, rsp_resp, rsp_timeout} !== e || cyc != 3) begin
            n_fail++; $display("FAIL write_rsp: got %h/%h/%b at %0d required %h/%h/%b at 3",
                               rsp_rdata, rsp_resp, rsp_timeout, cyc, e.rdata, e.resp, e.to);
        end
        send(1'b0, 32'h0000_000C, 32'h0);
        sb.push_back({32'h0000_C350, RESP_OKAY, 1'b0});
        wait_rsp(40, cyc);
        e = sb.pop_front();
        n_chk++;
        if ({rsp_rdata, rsp_resp, rsp_timeout} !== e || cyc != 3) begin
            n_fail++; $display("FAIL readback: got %h/%h/%b at %0d required %h/%h/%b at 3",
                               rsp_rdata, rsp_resp, rsp_timeout, cyc, e.rdata, e.resp, e.to);
        end
        @(negedge clk);
        n_chk++;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL pulse_width: rsp_valid=%b required 0", rsp_valid); end
    endtask

    task automatic test_aw_w_skew();
        int w_last = 0, aw_last = 0, b_first = 0, rsp_c = 0, addr_bad = 0;
        cfg_aw_dly = 5; cfg_w_dly = 1;
        send(1'b1, 32'h0000_0004, 32'hA5A5_0001);
        sb.push_back({32'h0, RESP_OKAY, 1'b0});
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (axio.wvalid) w_last = c;
            if (axio.awvalid) begin
                aw_last = c;
                if (axio.awaddr !== 32'h0000_0004) addr_bad++;
            end
            if (axio.bready && b_first == 0) b_first = c;
            if (rsp_valid === 1'b1) begin
                rsp_c = c;
                e = sb.pop_front();
                n_chk++;
                if ({rsp_rdata, rsp_resp, rsp_timeout} !== e) begin
                    n_fail++; $display("FAIL skew_rsp: got %h/%h/%b required %h/%h/%b",
                                       rsp_rdata, rsp_resp, rsp_timeout, e.rdata, e.resp, e.to);
                end
                break;
            end
        end
        n_chk++;
        if (w_last != 2 || aw_last != 6 || b_first != 7 || rsp_c != 8 || addr_bad != 0) begin
            n_fail++; $display("FAIL skew_timing: w_last=%0d aw_last=%0d b_first=%0d rsp=%0d addr_bad=%0d required 2 6 7 8 0",
                               w_last, aw_last, b_first, rsp_c, addr_bad);
        end
        cfg_aw_dly = 0; cfg_w_dly = 0;
    endtask

    task automatic test_back_to_back();
        int cyc;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h1000_0004; cmd_wdata = 32'h0000_03E8;
        sb.push_back({32'h0, RESP_OKAY, 1'b0});
        @(posedge clk); #1;
        cmd_we = 1'b0; cmd_wdata = 32'h0;
        sb.push_back({32'h0000_03E8, RESP_OKAY, 1'b0});
        wait_rsp(40, cyc);
        e = sb.pop_front();
        n_chk++;
        if ({rsp_rdata, rsp_resp, rsp_timeout} !== e || cmd_ready !== 1'b1 || cyc != 3) begin
            n_fail++; $display("FAIL b2b_write: got %h/%h/%b ready=%b at %0d required %h/%h/%b ready=1 at 3",
                               rsp_rdata, rsp_resp, rsp_timeout, cmd_ready, cyc, e.rdata, e.resp, e.to);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_rsp(40, cyc);
        e = sb.pop_front();
        n_chk++;
        if ({rsp_rdata, rsp_resp, rsp_timeout} !== e || cyc != 3) begin
            n_fail++; $display("FAIL b2b_read: got %h/%h/%b at %0d required %h/%h/%b at 3",
                               rsp_rdata, rsp_resp, rsp_timeout, cyc, e.rdata, e.resp, e.to);
        end
    endtask

    task automatic test_timeout();
        int ar_last = 0, rsp_c = 0, cyc;
        cfg_ar_never = 1'b1;
        send(1'b0, 32'h0000_0004, 32'h0);
        sb.push_back({32'h0, RESP_TIMEOUT, 1'b1});
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (axio.arvalid) ar_last = c;
            if (rsp_valid === 1'b1) begin
                rsp_c = c;
                e = sb.pop_front();
                n_chk++;
                if ({rsp_rdata, rsp_resp, rsp_timeout} !== e || axio.arvalid !== 1'b0) begin
                    n_fail++; $display("FAIL timeout_rsp: got %h/%h/%b arvalid=%b required %h/%h/%b arvalid=0",
                                       rsp_rdata, rsp_resp, rsp_timeout, axio.arvalid, e.rdata, e.resp, e.to);
                end
                break;
            end
        end
        n_chk++;
        if (ar_last != 16 || rsp_c != 17) begin
            n_fail++; $display("FAIL timeout_timing: ar_last=%0d rsp=%0d required 16 17", ar_last, rsp_c);
        end
        cfg_ar_never = 1'b0;
        send(1'b0, 32'h0000_000C, 32'h0);
        sb.push_back({32'h0000_C350, RESP_OKAY, 1'b0});
        wait_rsp(40, cyc);
        e = sb.pop_front();
        n_chk++;
        if ({rsp_rdata, rsp_resp, rsp_timeout} !== e || cyc != 3) begin
            n_fail++; $display("FAIL after_timeout: got %h/%h/%b at %0d required %h/%h/%b at 3",
                               rsp_rdata, rsp_resp, rsp_timeout, cyc, e.rdata, e.resp, e.to);
        end
    endtask

    task automatic test_reset_mid();
        int found = 0, pulses = 0, cyc;
        cfg_b_never = 1'b1;
        send(1'b1, 32'h0000_000C, 32'h0000_1234);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (axio.bready === 1'b1) begin found = 1; break; end
        end
        n_chk++;
        if (found != 1) begin n_fail++; $display("FAIL reach_wresp: found=%0d required 1", found); end
        rstn = 1'b0;
        #1;
        n_chk++;
        if ({axio.awvalid, axio.wvalid, axio.bready, axio.arvalid, axio.rready, rsp_valid} !== 6'b0) begin
            n_fail++; $display("FAIL mid_reset: hs=%b required 000000",
                               {axio.awvalid, axio.wvalid, axio.bready, axio.arvalid, axio.rready, rsp_valid});
        end
        @(negedge clk);
        rstn = 1'b1;
        cfg_b_never = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) pulses++;
        end
        n_chk++;
        if (pulses != 0 || cmd_ready !== 1'b1 || sb.size() != 0) begin
            n_fail++; $display("FAIL post_reset: pulses=%0d ready=%b pending=%0d required 0 1 0",
                               pulses, cmd_ready, sb.size());
        end
        send(1'b0, 32'h0, 32'h0);
        sb.push_back({32'h2904_2023, RESP_OKAY, 1'b0});
        wait_rsp(40, cyc);
        e = sb.pop_front();
        n_chk++;
        if ({rsp_rdata, rsp_resp, rsp_timeout} !== e || cyc != 3) begin
            n_fail++; $display("FAIL post_reset_read: got %h/%h/%b at %0d required %h/%h/%b at 3",
                               rsp_rdata, rsp_resp, rsp_timeout, cyc, e.rdata, e.resp, e.to);
        end
    endtask

    initial begin
        test_reset();
        test_id_read();
        test_write_read();
        test_aw_w_skew();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
